// File: rtl/code_pkg.sv
// Shared code/line widths, decoder FSM states and the one-hot helper.
// Also used by the 8-to-3 encoder side of the link.
package code_pkg;
   localparam int CODE_W = 3;
   localparam int LINE_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } dec_state_t;

   function automatic logic [LINE_W-1:0] onehot(input logic [CODE_W-1:0] code);
      return {{(LINE_W-1){1'b0}}, 1'b1} << code;
   endfunction
endpackage

// File: rtl/code_fifo.sv
// Generic FIFO with a registered occupancy count; dout shows the head entry combinationally.
// A push is refused when full and a pop when empty, with no ready-through when full.
module code_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DW-1:0]          din,
   input  logic                   pop,
   output logic [DW-1:0]          dout,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign level   = level_q;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule

// File: rtl/code_decoder_stream.sv
// Buffers 3-bit codes and replays each as a registered one-hot word held HOLD cycles; first word one edge after acceptance.
// in_ready follows registered FIFO occupancy only; words are emitted back to back with no idle gap.
module code_decoder_stream
   import code_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int HOLD  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [CODE_W-1:0]      in_code,
   output logic                   in_ready,
   output logic [LINE_W-1:0]      out,
   output logic                   out_valid,
   output logic [$clog2(DEPTH):0] level
);
   localparam int HW = $clog2(HOLD) + 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

   dec_state_t        state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [LINE_W-1:0] out_q, out_d;
   logic              out_valid_q, out_valid_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic [CODE_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;

   code_fifo #(
      .DEPTH (DEPTH),
      .DW    (CODE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (in_code),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      fifo_pop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               out_d       = onehot(fifo_dout);
               out_valid_d = 1'b1;
               hold_d      = HOLD_LOAD;
               state_d     = DRIVE;
            end else begin
               out_d       = '0;
               out_valid_d = 1'b0;
            end
         end
         DRIVE: begin
            if (hold_q != '0) begin
               hold_d = hold_q - HW'(1);
            end else if (!fifo_empty) begin
               // Reload on the last hold cycle so consecutive words abut.
               fifo_pop    = 1'b1;
               out_d       = onehot(fifo_dout);
               out_valid_d = 1'b1;
               hold_d      = HOLD_LOAD;
            end else begin
               out_d       = '0;
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_code_decoder_stream.sv
// Directed checks of the streaming one-hot decoder: u0 uses DEPTH=4/HOLD=2, u1 uses DEPTH=4/HOLD=1.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_code_decoder_stream;
   logic       clk;
   logic       rst;
   logic       in_valid0, in_valid1;
   logic [2:0] in_code0, in_code1;
   logic       in_ready0, in_ready1;
   logic [7:0] out0, out1;
   logic       out_valid0, out_valid1;
   logic [2:0] level0, level1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2:0] stim [0:15];
   int         stim_n;

   code_decoder_stream #(.DEPTH(4), .HOLD(2)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_code(in_code0),
      .in_ready(in_ready0), .out(out0), .out_valid(out_valid0), .level(level0)
   );

   code_decoder_stream #(.DEPTH(4), .HOLD(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_code(in_code1),
      .in_ready(in_ready1), .out(out1), .out_valid(out_valid1), .level(level1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      in_valid0 = 1'b0; in_code0 = '0;
      in_valid1 = 1'b0; in_code1 = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (out0 !== 8'h00)    begin n_bad++; $display("FAIL reset_out0: got %h want 00", out0); end
      n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_vld0: got %b want 0", out_valid0); end
      n_cmp++; if (level0 !== 3'd0)   begin n_bad++; $display("FAIL reset_level0: got %0d want 0", level0); end
      n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy0: got %b want 1", in_ready0); end
      n_cmp++; if (out1 !== 8'h00)    begin n_bad++; $display("FAIL reset_out1: got %h want 00", out1); end
      n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy1: got %b want 1", in_ready1); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] exp_out [0:4];
      logic       exp_vld [0:4];
      logic [2:0] exp_lvl [0:4];
      exp_out = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h00};
      exp_vld = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_lvl = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
      in_valid0 = 1'b1; in_code0 = 3'd3;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid0 = 1'b0;
         n_cmp++; if (out0 !== exp_out[c]) begin n_bad++; $display("FAIL single_out c%0d: got %h want %h", c, out0, exp_out[c]); end
         n_cmp++; if (out_valid0 !== exp_vld[c]) begin n_bad++; $display("FAIL single_vld c%0d: got %b want %b", c, out_valid0, exp_vld[c]); end
         n_cmp++; if (level0 !== exp_lvl[c]) begin n_bad++; $display("FAIL single_level c%0d: got %0d want %0d", c, level0, exp_lvl[c]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_out [0:5];
      exp_out = '{8'h00, 8'h01, 8'h01, 8'h80, 8'h80, 8'h00};
      in_valid0 = 1'b1; in_code0 = 3'd0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) in_code0 = 3'd7;
         else        in_valid0 = 1'b0;
         n_cmp++; if (out0 !== exp_out[c]) begin n_bad++; $display("FAIL b2b_out c%0d: got %h want %h", c, out0, exp_out[c]); end
         n_cmp++; if (out_valid0 !== (exp_out[c] != 8'h00)) begin n_bad++; $display("FAIL b2b_vld c%0d: got %b want %b", c, out_valid0, exp_out[c] != 8'h00); end
      end
   endtask

   // Holds in_valid on u0 through stim[0..stim_n-1]; every valid cycle must carry the next expected word.
   task automatic drive_stream(input string tag);
      int   sent = 0;
      int   got  = 0;
      logic saw_full = 1'b0;
      logic [7:0] want;
      for (int cyc = 0; cyc < 300 && got < stim_n * 2; cyc++) begin
         n_cmp++; if (in_ready0 !== (level0 < 3'd4)) begin n_bad++; $display("FAIL %s_rdy cyc%0d: got %b want %b (level %0d)", tag, cyc, in_ready0, level0 < 3'd4, level0); end
         n_cmp++; if (level0 > 3'd4) begin n_bad++; $display("FAIL %s_level cyc%0d: got %0d want <=4", tag, cyc, level0); end
         if (in_ready0 === 1'b0) saw_full = 1'b1;
         if (out_valid0 === 1'b1) begin
            want = 8'b1 << stim[got / 2];
            n_cmp++; if (out0 !== want) begin n_bad++; $display("FAIL %s_word %0d: got %h want %h", tag, got, out0, want); end
            got++;
         end else if (cyc > 1) begin
            n_cmp++; if (out0 !== 8'h00) begin n_bad++; $display("FAIL %s_idle cyc%0d: got %h want 00", tag, cyc, out0); end
         end
         if (sent < stim_n) begin
            in_valid0 = 1'b1;
            in_code0  = stim[sent];
            if (in_ready0 === 1'b1) sent++;
         end else begin
            in_valid0 = 1'b0;
         end
         @(negedge clk);
      end
      in_valid0 = 1'b0;
      n_cmp++; if (got != stim_n * 2) begin n_bad++; $display("FAIL %s_count: got %0d valid cycles want %0d", tag, got, stim_n * 2); end
      n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL %s_full: in_ready low seen %b want 1", tag, saw_full); end
      repeat (2) @(negedge clk);
      n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL %s_drain_vld: got %b want 0", tag, out_valid0); end
      n_cmp++; if (level0 !== 3'd0) begin n_bad++; $display("FAIL %s_drain_level: got %0d want 0", tag, level0); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 7; i++) stim[i] = 3'(i + 1);
      stim_n = 7;
      drive_stream("bp");
   endtask

   task automatic test_pointer_wrap();
      for (int i = 0; i < 13; i++) stim[i] = 3'((i * 3 + 1) % 8);
      stim_n = 13;
      drive_stream("wrap");
   endtask

   task automatic test_full_rate();
      logic [7:0] want;
      in_valid1 = 1'b1; in_code1 = 3'd0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c < 8) in_code1 = 3'(c);
         else       in_valid1 = 1'b0;
         want = (c >= 2 && c <= 9) ? (8'b1 << (c - 2)) : 8'h00;
         n_cmp++; if (out1 !== want) begin n_bad++; $display("FAIL rate_out c%0d: got %h want %h", c, out1, want); end
         n_cmp++; if (out_valid1 !== (want != 8'h00)) begin n_bad++; $display("FAIL rate_vld c%0d: got %b want %b", c, out_valid1, want != 8'h00); end
         n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL rate_rdy c%0d: got %b want 1", c, in_ready1); end
      end
   endtask

   task automatic test_reset_mid_drive();
      logic [2:0] codes [0:5];
      codes = '{3'd0, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4};
      in_valid0 = 1'b1; in_code0 = codes[0];
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c < 6) in_code0 = codes[c];
      end
      // Five codes in: 0 consumed, 5 on out, 1/2/3 buffered.
      n_cmp++; if (out0 !== 8'h20) begin n_bad++; $display("FAIL mid_pre_out: got %h want 20", out0); end
      n_cmp++; if (level0 !== 3'd3) begin n_bad++; $display("FAIL mid_pre_level: got %0d want 3", level0); end
      in_valid0 = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++; if (out0 !== 8'h00) begin n_bad++; $display("FAIL mid_rst_out: got %h want 00", out0); end
      n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_vld: got %b want 0", out_valid0); end
      n_cmp++; if (level0 !== 3'd0) begin n_bad++; $display("FAIL mid_rst_level: got %0d want 0", level0); end
      n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy: got %b want 1", in_ready0); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++; if (out_valid0 !== 1'b0 || out0 !== 8'h00) begin n_bad++; $display("FAIL mid_post c%0d: got vld %b out %h want 0/00", c, out_valid0, out0); end
         n_cmp++; if (level0 !== 3'd0) begin n_bad++; $display("FAIL mid_post_level c%0d: got %0d want 0", c, level0); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_full_rate();
      test_reset_mid_drive();
      test_pointer_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/code_decoder_stream.md
# code_decoder_stream

Streaming 3-to-8 one-hot decoder: the return path for the 8-to-3 priority encoder. It accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a registered one-hot byte held for a programmable number of cycles. It sits downstream of the encoder link and regenerates per-line strobes in arrival order.

## Interface
Parameters:
- DEPTH, 4, FIFO entries. Must be a power of 2, ≥2.
- HOLD, 2, cycles each one-hot word is driven. Must be ≥1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- in_valid  input  1  in_code is presented.
- in_code  input  3  binary line index, 0..7.
- in_ready  output  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- out  output  8  registered one-hot word, `1 << code`, or 8'h00 when idle.
- out_valid  output  1  high while out carries a decoded word.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- Reset values: out=8'h00, out_valid=0, level=0, in_ready=1, FSM=IDLE, pointers=0, hold counter=0.
- FIFO:
  - in_ready = (level < DEPTH), from registered occupancy only.
  - When full, a push is refused even if a pop occurs in the same cycle. There is no combinational ready-through.
  - Push and pop in the same cycle leave level unchanged.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Order is strictly FIFO.
- FSM states: IDLE, DRIVE.
  - IDLE, level==0: out=8'h00, out_valid=0, stay in IDLE.
  - IDLE, level>0: pop the head, load out = 1<<head, out_valid=1, hold_cnt = HOLD-1, go to DRIVE.
  - DRIVE, hold_cnt>0: decrement hold_cnt; out is unchanged.
  - DRIVE, hold_cnt==0, level>0: pop the next code, reload out and hold_cnt, stay in DRIVE. There is no idle gap between words.
  - DRIVE, hold_cnt==0, level==0: out=8'h00, out_valid=0, go to IDLE.
- Width rules:
  - hold_cnt is $clog2(HOLD)+1 bits and never underflows.
  - in_code is always a valid index, so there is no default or illegal case.
  - out is exactly one-hot whenever out_valid=1, and zero otherwise.
- Reset asserted mid-operation: everything returns to reset values immediately, without waiting for a clock edge. Buffered codes are discarded. A word being driven drops to 8'h00 at once.
- in_code is ignored when in_valid=0 or in_ready=0.

## Timing
- Latency:
  - A code accepted at edge N, with the FIFO empty and the FSM in IDLE, appears on out after edge N+1.
  - It is held for exactly HOLD cycles.
- Throughput:
  - One code per HOLD cycles at steady state.
  - With HOLD=1, one code per cycle with no bubbles once the FIFO is primed.
- in_ready:
  - Falls the cycle after level reaches DEPTH.
  - Rises the cycle after the pop that makes level < DEPTH.
- The first word after reset can appear no earlier than two edges after rst deasserts (one edge to push, one edge to load).

## Structure
- Shared package `code_pkg`:
  - CODE_W=3, LINE_W=8.
  - FSM state enum {IDLE, DRIVE}.
  - Shared with the encoder side.
- Natural sub-module: `code_fifo`.
  - Parameterized by DEPTH and data width.
  - Ports: clk, rst, push, din, pop, dout, level, full, empty.
- The top level holds the FSM, hold counter and output register. Target size is roughly 150–250 lines total.

## Test plan
- Single code: reset, then push code 3 with HOLD=2.
  - out=8'h08 with out_valid=1 for exactly 2 cycles, starting one cycle after acceptance.
  - Then out=8'h00 and out_valid=0; level goes 1 then 0.
- Back-to-back: push 0 then 7 on consecutive cycles, HOLD=2.
  - out=8'h01 for 2 cycles, immediately followed by 8'h80 for 2 cycles, with no gap.
- Backpressure: DEPTH=4, HOLD=2, hold in_valid high with codes 1,2,3,4,5,6,7.
  - in_ready deasserts once level=4; no code is lost or duplicated.
  - Outputs appear in order: 02, 04, 08, 10, 20, 40, 80.
- Full rate: HOLD=1, stream codes 0..7 every cycle.
  - out steps 01, 02, 04, … 80 on consecutive cycles; out_valid is continuous for 8 cycles.
- Reset mid-drive: assert rst while out=8'h20 with 3 codes buffered.
  - out=8'h00, out_valid=0, level=0 and in_ready=1 immediately.
  - After release, nothing is emitted until a new push.
- Pointer wrap: push and drain 3×DEPTH+1 codes.
  - Order is preserved across wrap; level never exceeds DEPTH.
